// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port MemoryUnit bus arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 27;
  localparam int DATA_W_DEF = 32;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

  // MemoryUnit region bases, handy for benches and address decoding.
  localparam logic [ADDR_W_DEF-1:0] REGION_SDRAM  = 27'h000_0000;
  localparam logic [ADDR_W_DEF-1:0] REGION_FLASH  = 27'h080_0000;
  localparam logic [ADDR_W_DEF-1:0] REGION_VRAM32 = 27'h0C0_0000;
  localparam logic [ADDR_W_DEF-1:0] REGION_IO     = 27'h0C0_2622;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: combinational grant from the current requests,
// with a registered "last granted" pointer that demotes the previous owner.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_port,
  output logic [1:0] gnt
);

  // Last-granted port; starts at 1 so that port 0 wins the first tie.
  logic last_q;

  // Pointer register, loaded with the finished owner when strobed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else if (update) begin
      last_q <= upd_port;
    end
  end

  // Single requester wins outright; on a tie the port not granted last wins.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the MemoryUnit CPU-side bus between two req/ack requesters, sequencing
// the start/busy handshake with round-robin fairness, init gating and a timeout.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p0_we,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_q,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p1_we,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              mem_start,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_init_done,
  output logic              owner,
  output logic              active
);

  // Counter value at which an outstanding access is forcibly abandoned.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              owner_q, owner_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA_W-1:0] q0_q, q0_d, q1_q, q1_d;

  logic [1:0] gnt;
  logic       arb_update;

  rr_arb2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      ({p1_req, p0_req}),
    .update   (arb_update),
    .upd_port (owner_q),
    .gnt      (gnt)
  );

  // State and output registers; every bus-facing signal comes from a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      start_q <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      q0_q    <= '0;
      q1_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      start_q <= start_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
    end
  end

  // Next-state logic: grant, hold start through busy, complete or time out.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;
    start_d    = start_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    err0_d     = 1'b0;
    err1_d     = 1'b0;
    q0_d       = q0_q;
    q1_d       = q1_q;
    arb_update = 1'b0;

    case (state_q)
      IDLE: begin
        // A stuck-busy MemoryUnit or an unfinished init blocks new grants.
        if (mem_init_done && !mem_busy && (gnt != 2'b00)) begin
          owner_d = gnt[1];
          addr_d  = gnt[1] ? p1_addr : p0_addr;
          data_d  = gnt[1] ? p1_data : p0_data;
          we_d    = gnt[1] ? p1_we   : p0_we;
          start_d = 1'b1;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end

      ISSUE, WAIT: begin
        cnt_d = cnt_q + TO_W'(1);
        if (cnt_q == TO_LAST) begin
          // Timeout wins over any busy edge seen in the same cycle.
          start_d = 1'b0;
          state_d = GAP;
          if (owner_q) begin
            q1_d   = '0;
            ack1_d = 1'b1;
            err1_d = 1'b1;
          end else begin
            q0_d   = '0;
            ack0_d = 1'b1;
            err0_d = 1'b1;
          end
        end else if (state_q == ISSUE) begin
          if (mem_busy) begin
            state_d = WAIT;
          end
        end else if (!mem_busy) begin
          // Drop start right away so MemoryUnit cannot re-trigger.
          start_d = 1'b0;
          state_d = GAP;
          if (owner_q) begin
            q1_d   = mem_q;
            ack1_d = 1'b1;
          end else begin
            q0_d   = mem_q;
            ack0_d = 1'b1;
          end
        end
      end

      GAP: begin
        // Requester gets a cycle to drop req; demote the finished owner.
        arb_update = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_we      = we_q;
  assign mem_start   = start_q;
  assign owner       = owner_q;
  assign active      = (state_q == ISSUE) || (state_q == WAIT);
  assign p0_ack      = ack0_q;
  assign p1_ack      = ack1_q;
  assign p0_err      = err0_q;
  assign p1_err      = err1_q;
  assign p0_q        = q0_q;
  assign p1_q        = q1_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single MemoryUnit CPU-side bus (address/data/we/start/busy/q) between two requesters, e.g. CPU and a DMA/blitter engine.
- Uses a simple req/ack protocol toward the requesters.
- Sequences the MemoryUnit start/busy handshake, including dropping start after completion.
- Adds round-robin fairness, init gating, and a lockup timeout.
- Sits between the requesters and MemoryUnit; runs on the rising edge of clk, while MemoryUnit runs on the falling edge.

Parameters:
- ADDR_W, 27, MemoryUnit address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 4096, max cycles in ISSUE+WAIT before forced abort; must be ≥2
- TO_W, 13, timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- p0_req  in  1  port 0 request; held with addr/data/we stable until p0_ack
- p0_addr  in  ADDR_W  port 0 address
- p0_data  in  DATA_W  port 0 write data
- p0_we  in  1  port 0 write enable (1=write, 0=read)
- p0_ack  out  1  one-cycle completion pulse
- p0_err  out  1  one-cycle pulse coincident with p0_ack on timeout
- p0_q  out  DATA_W  read data; valid from p0_ack and held until the next port-0 completion
- p1_req, p1_addr, p1_data, p1_we, p1_ack, p1_err, p1_q  —  port 1, identical to port 0
- mem_address  out  ADDR_W  to MemoryUnit address
- mem_data  out  DATA_W  to MemoryUnit data
- mem_we  out  1  to MemoryUnit we
- mem_start  out  1  to MemoryUnit start
- mem_busy  in  1  from MemoryUnit busy
- mem_q  in  DATA_W  from MemoryUnit q
- mem_init_done  in  1  from MemoryUnit initDone
- owner  out  1  port currently or last granted (debug)
- active  out  1  high in ISSUE/WAIT

Behaviour:
- Reset (async, any state): state=IDLE; the following are all 0: mem_start, mem_we, mem_address, mem_data, pX_ack, pX_err, pX_q, owner, active, timeout counter.
  - Round-robin pointer resets so that port 0 wins the first tie.
- All mem_* outputs, acks and q are registered; there is no combinational path from requester inputs to mem_* outputs.
- State machine:
  - IDLE: grant only if mem_init_done=1, mem_busy=0 and at least one req.
    - Winner: the single requester if only one is active; on tie, the port not granted last.
    - On grant: latch winner addr/data/we into mem_*; mem_start<=1; owner<=winner; counter<=0; go to ISSUE.
  - ISSUE: mem_start held at 1; counter increments each cycle.
    - mem_busy=1 → WAIT.
  - WAIT: mem_start held at 1; counter increments each cycle.
    - mem_busy=0 → mem_start<=0; pOwner_q<=mem_q (captured on writes too); pOwner_ack<=1 for exactly one cycle; go to GAP.
  - Timeout: in ISSUE or WAIT, when the counter reaches TIMEOUT_CYCLES-1:
    - mem_start<=0; pOwner_q<=0; pOwner_ack<=1 and pOwner_err<=1 for one cycle; go to GAP.
    - Timeout takes precedence over a simultaneous busy transition.
  - GAP: one cycle with no grant, giving the requester time to drop req; pointer updated so the last owner has lowest priority; go to IDLE.
- Latency:
  - Request grant: req sampled in IDLE at edge N → mem_start=1 after edge N.
  - Completion: busy seen low in WAIT at edge M → ack high after edge M.
  - Minimum req-to-ack is 3 cycles for a single-negedge MemoryUnit access.
  - Back-to-back grants are separated by at least 2 cycles (GAP + IDLE).
- mem_start is never high in IDLE or GAP. The 1→0 transition happens within one cycle of busy falling, so MemoryUnit never re-triggers.
- A req dropped mid-transaction is ignored: the transaction completes and the ack is still issued.
- mem_init_done falling while in ISSUE/WAIT does not abort; it only blocks new grants.
- If mem_busy is stuck high after a timeout, IDLE issues no further grants until busy clears.
- The acked port's req during GAP is never counted as a new request.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, GAP}
  - ADDR_W/DATA_W defaults
  - MemoryUnit region base constants (SDRAM 0x000000, FLASH 0x800000, VRAM32 0xC00000, IO 0xC02622) for benches
- Sub-module rr_arb2: combinational 2-way round-robin pick plus registered last-grant pointer; inputs req[1:0], update strobe; outputs gnt[1:0].

Test Plan:
- Port 0 read 0x000010; model sets busy 1 negedge after start, returns q=0xDEADBEEF 4 cycles later → p0_ack single pulse, p0_q=0xDEADBEEF, p0_err=0, mem_start low by the cycle after ack.
- p0 and p1 requesting continuously (p0 write 0xC00000 data 0x12345678, p1 read 0x800004) → grants alternate p0,p1,p0,p1; each ack exactly once per transaction; mem_we=1 only during p0 transactions.
- mem_init_done=0 with p1_req=1 for 50 cycles → mem_start stays 0; raise init_done → mem_start=1 within 2 cycles.
- Model never asserts busy, TIMEOUT_CYCLES=16 → exactly 16 cycles after the grant, p0_ack=1 with p0_err=1 and p0_q=0; mem_start=0 thereafter.
- Assert reset during WAIT → same cycle mem_start=0, active=0, no ack; after reset release with p1_req=1 → port 0 has priority on tie, p1 granted alone.
- Single port holding req after ack for 1 cycle (GAP) → no duplicate grant; req held 2+ cycles → second transaction issued.
